// File: rtl/ysyx_22040088_seqctl.sv
// Multi-cycle instruction sequencer: walks each instruction through
// fetch, decode, execute, optional data-memory access and write-back,
// counts retired instructions and halts on ebreak or on a stalled handshake.
//
// Handshakes: a request strobe (ifu_req, lsu_req) stays high for every cycle
// the FSM sits in the requesting state; the transfer happens in the cycle the
// matching response (ifu_rdy, ifu_rvalid, lsu_ack) is sampled high, and the
// FSM leaves the state on that clock edge. Responses seen in any other state
// are ignored.
module ysyx_22040088_seqctl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        ifu_rdy,
    input  logic        ifu_rvalid,
    input  logic        dec_rf_we,
    input  logic        dec_mem_ena,
    input  logic        dec_mem_wen,
    input  logic        dec_halt,
    input  logic        lsu_ack,
    output logic        ifu_req,
    output logic        inst_le,
    output logic        pc_we,
    output logic        rf_we,
    output logic        lsu_req,
    output logic        lsu_we,
    output logic [2:0]  state,
    output logic        halted,
    output logic        err,
    output logic [63:0] retired
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = (TW > 8) ? TW : 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAITI  = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_MEM    = 3'd5,
        S_WB     = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    state_t          cur;
    state_t          nxt;
    logic [CW-1:0]   wcnt;
    logic            wait_expired;
    logic            to_err;
    logic            in_wait_state;

    assign state         = cur;
    assign wait_expired  = (wcnt == CW'(TIMEOUT));
    assign in_wait_state = (cur == S_FETCH) || (cur == S_WAITI) || (cur == S_MEM);

    // Strobes that must follow their input in the same cycle.
    assign inst_le = (cur == S_WAITI) && ifu_rvalid;
    assign rf_we   = (cur == S_WB) && dec_rf_we && !dec_mem_wen;
    assign lsu_we  = (cur == S_MEM) && dec_mem_wen;

    // Next-state selection; a handshake always wins over an expiring wait.
    always_comb begin
        nxt    = cur;
        to_err = 1'b0;
        case (cur)
            S_IDLE:   if (run) nxt = S_FETCH;
            S_FETCH: begin
                if (ifu_rdy) nxt = S_WAITI;
                else if (wait_expired) begin
                    nxt    = S_HALT;
                    to_err = 1'b1;
                end
            end
            S_WAITI: begin
                if (ifu_rvalid) nxt = S_DECODE;
                else if (wait_expired) begin
                    nxt    = S_HALT;
                    to_err = 1'b1;
                end
            end
            S_DECODE: nxt = dec_halt ? S_HALT : S_EXEC;
            S_EXEC:   nxt = dec_mem_ena ? S_MEM : S_WB;
            S_MEM: begin
                if (lsu_ack) nxt = S_WB;
                else if (wait_expired) begin
                    nxt    = S_HALT;
                    to_err = 1'b1;
                end
            end
            S_WB:     nxt = run ? S_FETCH : S_IDLE;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_HALT;
        endcase
    end

    // State, wait counter, Moore strobes (registered from next state) and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur     <= S_IDLE;
            wcnt    <= '0;
            ifu_req <= 1'b0;
            pc_we   <= 1'b0;
            lsu_req <= 1'b0;
            halted  <= 1'b0;
            err     <= 1'b0;
            retired <= '0;
        end else begin
            cur     <= nxt;
            ifu_req <= (nxt == S_FETCH);
            pc_we   <= (nxt == S_WB);
            lsu_req <= (nxt == S_MEM);
            halted  <= (nxt == S_HALT);
            if (to_err) err <= 1'b1;
            if (nxt != cur) wcnt <= '0;
            else if (in_wait_state) wcnt <= wcnt + 1'b1;
            // Retirement happens on the edge that ends the write-back cycle.
            if (cur == S_WB) retired <= retired + 64'd1;
        end
    end

endmodule

// File: tb/tb_ysyx_22040088_seqctl.sv
// Directed bench for the instruction sequencer (TIMEOUT overridden to 4).
module tb_ysyx_22040088_seqctl;

    logic        clk;
    logic        rst;
    logic        run;
    logic        ifu_rdy;
    logic        ifu_rvalid;
    logic        dec_rf_we;
    logic        dec_mem_ena;
    logic        dec_mem_wen;
    logic        dec_halt;
    logic        lsu_ack;
    logic        ifu_req;
    logic        inst_le;
    logic        pc_we;
    logic        rf_we;
    logic        lsu_req;
    logic        lsu_we;
    logic [2:0]  state;
    logic        halted;
    logic        err;
    logic [63:0] retired;

    int n_checks = 0;
    int n_errors = 0;
    logic [2:0] exp_q[$];

    ysyx_22040088_seqctl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .run(run),
        .ifu_rdy(ifu_rdy), .ifu_rvalid(ifu_rvalid),
        .dec_rf_we(dec_rf_we), .dec_mem_ena(dec_mem_ena),
        .dec_mem_wen(dec_mem_wen), .dec_halt(dec_halt),
        .lsu_ack(lsu_ack),
        .ifu_req(ifu_req), .inst_le(inst_le), .pc_we(pc_we),
        .rf_we(rf_we), .lsu_req(lsu_req), .lsu_we(lsu_we),
        .state(state), .halted(halted), .err(err), .retired(retired)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock, sampling 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance and compare state against the next scoreboard entry.
    task automatic tick_exp(input string tag);
        tick();
        if (exp_q.size() == 0) begin
            check({tag, "_q_empty"}, 64'd1, 64'd0);
        end else begin
            check(tag, {61'd0, state}, {61'd0, exp_q.pop_front()});
        end
    endtask

    // From FETCH: ifu_rdy after rdy_lat cycles, ifu_rvalid after val_lat cycles; ends in DECODE.
    task automatic go_to_decode(input int rdy_lat, input int val_lat);
        for (int i = 0; i < rdy_lat; i++) begin
            ifu_rdy = 1'b0;
            tick();
            check("fetch_wait", {61'd0, state}, 64'd1);
        end
        ifu_rdy = 1'b1;
        tick();
        ifu_rdy = 1'b0;
        check("to_waiti", {61'd0, state}, 64'd2);
        check("waiti_ifu_req", {63'd0, ifu_req}, 64'd0);
        for (int j = 0; j < val_lat; j++) begin
            ifu_rvalid = 1'b0;
            #1;
            check("inst_le_idle", {63'd0, inst_le}, 64'd0);
            tick();
            check("waiti_wait", {61'd0, state}, 64'd2);
        end
        ifu_rvalid = 1'b1;
        #1;
        check("inst_le_on", {63'd0, inst_le}, 64'd1);
        tick();
        ifu_rvalid = 1'b0;
        check("to_decode", {61'd0, state}, 64'd3);
        check("inst_le_off", {63'd0, inst_le}, 64'd0);
    endtask

    task automatic clear_dec();
        dec_rf_we   = 1'b0;
        dec_mem_ena = 1'b0;
        dec_mem_wen = 1'b0;
        dec_halt    = 1'b0;
        lsu_ack     = 1'b0;
    endtask

    initial begin
        int req_cycles;
        rst = 1'b0; run = 1'b1; ifu_rdy = 1'b0; ifu_rvalid = 1'b0;
        clear_dec();

        // Reset holds IDLE even with run high
        repeat (3) tick();
        check("rst_state", {61'd0, state}, 64'd0);
        check("rst_retired", retired, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_halted", {63'd0, halted}, 64'd0);
        check("rst_ifu_req", {63'd0, ifu_req}, 64'd0);
        check("rst_pc_we", {63'd0, pc_we}, 64'd0);
        rst = 1'b1;
        #1;
        check("post_rst_idle", {61'd0, state}, 64'd0);

        // ALU instruction, ifu_rdy and ifu_rvalid each one cycle late
        exp_q = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd6, 3'd1};
        tick_exp("alu_fetch");
        check("alu_ifu_req", {63'd0, ifu_req}, 64'd1);
        tick_exp("alu_fetch_late");
        ifu_rdy = 1'b1;
        tick_exp("alu_waiti");
        ifu_rdy = 1'b0;
        #1;
        check("alu_inst_le_lo", {63'd0, inst_le}, 64'd0);
        tick_exp("alu_waiti_late");
        ifu_rvalid = 1'b1;
        #1;
        check("alu_inst_le_hi", {63'd0, inst_le}, 64'd1);
        tick_exp("alu_decode");
        ifu_rvalid = 1'b0;
        dec_rf_we = 1'b1;
        tick_exp("alu_exec");
        check("alu_exec_pc_we", {63'd0, pc_we}, 64'd0);
        tick_exp("alu_wb");
        check("alu_wb_pc_we", {63'd0, pc_we}, 64'd1);
        check("alu_wb_rf_we", {63'd0, rf_we}, 64'd1);
        check("alu_wb_retired", retired, 64'd0);
        tick_exp("alu_next_fetch");
        check("alu_pc_we_off", {63'd0, pc_we}, 64'd0);
        check("alu_rf_we_off", {63'd0, rf_we}, 64'd0);
        check("alu_retired", retired, 64'd1);
        clear_dec();

        // Store with lsu_ack after three cycles; rf_we must stay gated off
        go_to_decode(0, 0);
        dec_mem_ena = 1'b1; dec_mem_wen = 1'b1; dec_rf_we = 1'b1;
        tick();
        check("st_exec", {61'd0, state}, 64'd4);
        check("st_exec_lsu_req", {63'd0, lsu_req}, 64'd0);
        tick();
        req_cycles = 0;
        for (int c = 0; c < 4; c++) begin
            lsu_ack = (c == 3);
            #1;
            check("st_mem_state", {61'd0, state}, 64'd5);
            check("st_lsu_we", {63'd0, lsu_we}, 64'd1);
            if (lsu_req) req_cycles++;
            tick();
        end
        lsu_ack = 1'b0;
        check("st_lsu_req_cycles", req_cycles, 64'd4);
        check("st_wb", {61'd0, state}, 64'd6);
        check("st_wb_lsu_req", {63'd0, lsu_req}, 64'd0);
        check("st_wb_lsu_we", {63'd0, lsu_we}, 64'd0);
        check("st_wb_rf_we", {63'd0, rf_we}, 64'd0);
        check("st_wb_pc_we", {63'd0, pc_we}, 64'd1);
        tick();
        check("st_retired", retired, 64'd2);
        check("st_fetch", {61'd0, state}, 64'd1);
        clear_dec();

        // run dropped during EXEC: instruction retires, then IDLE
        go_to_decode(0, 0);
        dec_rf_we = 1'b1;
        tick();
        check("rd_exec", {61'd0, state}, 64'd4);
        run = 1'b0;
        tick();
        check("rd_wb_pc_we", {63'd0, pc_we}, 64'd1);
        tick();
        check("rd_idle", {61'd0, state}, 64'd0);
        check("rd_retired", retired, 64'd3);
        tick();
        check("rd_stay_idle", {61'd0, state}, 64'd0);
        check("rd_ifu_req", {63'd0, ifu_req}, 64'd0);
        clear_dec();

        // ebreak; lsu_ack asserted while waiting for the instruction is ignored
        run = 1'b1;
        tick();
        check("eb_fetch", {61'd0, state}, 64'd1);
        lsu_ack = 1'b1;
        go_to_decode(0, 2);
        lsu_ack = 1'b0;
        dec_halt = 1'b1;
        tick();
        check("eb_halt", {61'd0, state}, 64'd7);
        check("eb_halted", {63'd0, halted}, 64'd1);
        check("eb_err", {63'd0, err}, 64'd0);
        check("eb_pc_we", {63'd0, pc_we}, 64'd0);
        check("eb_retired", retired, 64'd3);
        dec_halt = 1'b0;
        repeat (3) tick();
        check("eb_hold", {61'd0, state}, 64'd7);
        check("eb_hold_retired", retired, 64'd3);
        check("eb_hold_ifu_req", {63'd0, ifu_req}, 64'd0);

        // Asynchronous reset while a load sits in MEM
        rst = 1'b0;
        #1;
        check("halt_rst_state", {61'd0, state}, 64'd0);
        rst = 1'b1;
        tick();
        go_to_decode(0, 0);
        dec_rf_we = 1'b1;
        tick();
        tick();
        tick();
        check("ar_retired_pre", retired, 64'd1);
        clear_dec();
        go_to_decode(0, 0);
        dec_mem_ena = 1'b1; dec_rf_we = 1'b1;
        tick();
        tick();
        check("ar_mem", {61'd0, state}, 64'd5);
        check("ar_mem_lsu_req", {63'd0, lsu_req}, 64'd1);
        check("ar_mem_lsu_we", {63'd0, lsu_we}, 64'd0);
        #2;
        rst = 1'b0;
        #1;
        check("ar_state", {61'd0, state}, 64'd0);
        check("ar_retired", retired, 64'd0);
        check("ar_lsu_req", {63'd0, lsu_req}, 64'd0);
        check("ar_pc_we", {63'd0, pc_we}, 64'd0);
        check("ar_rf_we", {63'd0, rf_we}, 64'd0);
        clear_dec();
        run = 1'b0;
        rst = 1'b1;
        tick();
        check("ar_idle", {61'd0, state}, 64'd0);
        check("ar_no_pc_we", {63'd0, pc_we}, 64'd0);

        // Timeout: ifu_rdy never comes, counter runs 0..4 then HALT with err
        run = 1'b1;
        tick();
        check("to_fetch", {61'd0, state}, 64'd1);
        repeat (4) tick();
        check("to_still_fetch", {61'd0, state}, 64'd1);
        check("to_no_err_yet", {63'd0, err}, 64'd0);
        tick();
        check("to_halt", {61'd0, state}, 64'd7);
        check("to_err", {63'd0, err}, 64'd1);
        check("to_halted", {63'd0, halted}, 64'd1);

        // Handshake on the timeout cycle wins
        rst = 1'b0;
        #1;
        check("to_rst_err", {63'd0, err}, 64'd0);
        rst = 1'b1;
        tick();
        repeat (4) tick();
        check("hs_fetch", {61'd0, state}, 64'd1);
        ifu_rdy = 1'b1;
        tick();
        ifu_rdy = 1'b0;
        check("hs_waiti", {61'd0, state}, 64'd2);
        check("hs_err", {63'd0, err}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
